md_ctrl: RTL and testbench

- Issue/sequencing controller for the M-extension unit (RV64): takes one mul/div op from execute via valid/ready.
- Decodes md_op_t and the word-op flag, then launches the external multiplier or iterative divider.
- Resolves divide special cases itself (div_status_t) and applies sign fix-up / word sign-extension.
- Returns the result to writeback through a valid/ready response port. One op outstanding.

---
 rtl/md_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_md_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Issue/sequencing controller for an RV64 M-extension unit: launches the external multiplier or
// divider, resolves divide special cases locally. Optional macro MD_DIV_FASTPATH_EN also resolves
// zero-dividend and short divides (|divisor| > |dividend|) without using the divider.
module md_ctrl #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic              req_word_i,
  input  logic [XLEN-1:0]   req_rs1_i,
  input  logic [XLEN-1:0]   req_rs2_i,
  output logic              mul_start_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  output logic              mul_a_signed_o,
  output logic              mul_b_signed_o,
  input  logic              mul_done_i,
  input  logic [2*XLEN-1:0] mul_prod_i,
  output logic              div_start_o,
  output logic [XLEN-1:0]   div_dividend_o,
  output logic [XLEN-1:0]   div_divisor_o,
  input  logic              div_done_i,
  input  logic [XLEN-1:0]   div_quot_i,
  input  logic [XLEN-1:0]   div_rem_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_data_o,
  output logic [2:0]        resp_status_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_MUL_WAIT   = 3'd1;
  localparam logic [2:0] S_DIV_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP       = 3'd3;
  localparam logic [2:0] S_FLUSH_WAIT = 3'd4;

  localparam logic [2:0] ST_NONE          = 3'd0;
  localparam logic [2:0] ST_ZERO_DIVISOR  = 3'd1;
  localparam logic [2:0] ST_OVERFLOW      = 3'd2;
  localparam logic [2:0] ST_ZERO_DIVIDEND = 3'd3;
  localparam logic [2:0] ST_SHORT_DIV     = 3'd4;

  function automatic logic [XLEN-1:0] word_sext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic [2:0]      state_q, state_d;
  logic            start_q, start_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            a_signed_q, a_signed_d, b_signed_q, b_signed_d;
  logic            mul_high_q, mul_high_d, is_div_q, is_div_d, is_rem_q, is_rem_d;
  logic            neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, word_q, word_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [2:0]      status_q, status_d;

  // Request decode: undefined opcodes fold to MUL, W-variants of MULH* fold to MULW.
  logic [3:0]      op;
  logic            is_div, div_signed, is_rem, mul_high, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;

  always_comb begin
    op         = req_op_i[3] ? 4'd0 : req_op_i;
    is_div     = op[2];
    div_signed = is_div && !op[0];
    is_rem     = is_div && op[1];
    mul_high   = !is_div && !req_word_i && (op[1:0] != 2'd0);
    a_sgn      = mul_high && (op[1:0] != 2'd3);
    b_sgn      = mul_high && (op[1:0] == 2'd1);
    a_ext      = req_word_i ? {{(XLEN-32){div_signed & req_rs1_i[31]}}, req_rs1_i[31:0]} : req_rs1_i;
    b_ext      = req_word_i ? {{(XLEN-32){div_signed & req_rs2_i[31]}}, req_rs2_i[31:0]} : req_rs2_i;
    a_neg      = div_signed && a_ext[XLEN-1];
    b_neg      = div_signed && b_ext[XLEN-1];
    a_mag      = a_neg ? -a_ext : a_ext;
    b_mag      = b_neg ? -b_ext : b_ext;
    min_neg    = req_word_i ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic            sp_hit;
  logic [2:0]      sp_status;
  logic [XLEN-1:0] sp_q, sp_r, sp_res;

  always_comb begin
    sp_hit    = 1'b1;
    sp_status = ST_NONE;
    sp_q      = '0;
    sp_r      = '0;
    if (b_ext == '0) begin
      sp_status = ST_ZERO_DIVISOR;
      sp_q      = '1;
      sp_r      = a_ext;
    end else if (div_signed && (a_ext == min_neg) && (b_ext == '1)) begin
      sp_status = ST_OVERFLOW;
      sp_q      = a_ext;
`ifdef MD_DIV_FASTPATH_EN
    end else if (a_ext == '0) begin
      sp_status = ST_ZERO_DIVIDEND;
    end else if (b_mag > a_mag) begin
      sp_status = ST_SHORT_DIV;
      sp_r      = a_ext;
`endif
    end else begin
      sp_hit = 1'b0;
    end
    sp_res = word_sext(req_word_i, is_rem ? sp_r : sp_q);
  end

  // Unsigned unit results get sign fix-up; word ops keep the low 32 bits sign-extended.
  logic [XLEN-1:0] q_fix, r_fix, div_res, mul_res;
  logic            unit_done;

  always_comb begin
    q_fix     = neg_quot_q ? -div_quot_i : div_quot_i;
    r_fix     = neg_rem_q ? -div_rem_i : div_rem_i;
    div_res   = word_sext(word_q, is_rem_q ? r_fix : q_fix);
    mul_res   = word_sext(word_q, mul_high_q ? mul_prod_i[2*XLEN-1:XLEN] : mul_prod_i[XLEN-1:0]);
    unit_done = !start_q && (is_div_q ? div_done_i : mul_done_i);
  end

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    a_signed_d = a_signed_q;
    b_signed_d = b_signed_q;
    mul_high_d = mul_high_q;
    is_div_d   = is_div_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    word_d     = word_q;
    data_d     = data_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          a_d        = is_div ? a_mag : a_ext;
          b_d        = is_div ? b_mag : b_ext;
          a_signed_d = a_sgn;
          b_signed_d = b_sgn;
          mul_high_d = mul_high;
          is_div_d   = is_div;
          is_rem_d   = is_rem;
          neg_quot_d = div_signed && (a_neg ^ b_neg);
          neg_rem_d  = a_neg;
          word_d     = req_word_i;
          status_d   = ST_NONE;
          if (!is_div) begin
            state_d = S_MUL_WAIT;
            start_d = 1'b1;
          end else if (sp_hit) begin
            state_d  = S_RESP;
            data_d   = sp_res;
            status_d = sp_status;
          end else begin
            state_d = S_DIV_WAIT;
            start_d = 1'b1;
          end
        end
      end
      S_MUL_WAIT, S_DIV_WAIT: begin
        if (flush_i) begin
          state_d = unit_done ? S_IDLE : S_FLUSH_WAIT;
        end else if (unit_done) begin
          data_d  = is_div_q ? div_res : mul_res;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (flush_i || resp_ready_i) state_d = S_IDLE;
      end
      S_FLUSH_WAIT: begin
        if (unit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      mul_high_q <= 1'b0;
      is_div_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      word_q     <= 1'b0;
      data_q     <= '0;
      status_q   <= ST_NONE;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_signed_q <= a_signed_d;
      b_signed_q <= b_signed_d;
      mul_high_q <= mul_high_d;
      is_div_q   <= is_div_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      word_q     <= word_d;
      data_q     <= data_d;
      status_q   <= status_d;
    end
  end

  assign req_ready_o    = (state_q == S_IDLE) && !flush_i && !reset;
  assign mul_start_o    = (state_q == S_MUL_WAIT) && start_q;
  assign div_start_o    = (state_q == S_DIV_WAIT) && start_q;
  assign mul_a_o        = a_q;
  assign mul_b_o        = b_q;
  assign mul_a_signed_o = a_signed_q;
  assign mul_b_signed_o = b_signed_q;
  assign div_dividend_o = a_q;
  assign div_divisor_o  = b_q;
  assign resp_valid_o   = (state_q == S_RESP);
  assign resp_data_o    = data_q;
  assign resp_status_o  = status_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized bench for md_ctrl: behavioural multiplier/divider models plus a RISC-V M-extension
// reference model; directed cases cover special divides, flush, reset and response back-pressure.
module tb_md_ctrl;

  localparam logic [2:0] ST_NONE          = 3'd0;
  localparam logic [2:0] ST_ZERO_DIVISOR  = 3'd1;
  localparam logic [2:0] ST_OVERFLOW      = 3'd2;
  localparam logic [2:0] ST_ZERO_DIVIDEND = 3'd3;
  localparam logic [2:0] ST_SHORT_DIV     = 3'd4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush_i = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [3:0]   req_op_i = '0;
  logic         req_word_i = 1'b0;
  logic [63:0]  req_rs1_i = '0, req_rs2_i = '0;
  logic         mul_start_o, mul_a_signed_o, mul_b_signed_o;
  logic [63:0]  mul_a_o, mul_b_o;
  logic         mul_done_i = 1'b0;
  logic [127:0] mul_prod_i = '0;
  logic         div_start_o;
  logic [63:0]  div_dividend_o, div_divisor_o;
  logic         div_done_i = 1'b0;
  logic [63:0]  div_quot_i = '0, div_rem_i = '0;
  logic         resp_valid_o;
  logic         resp_ready_i = 1'b0;
  logic [63:0]  resp_data_o;
  logic [2:0]   resp_status_o;

  int total = 0;
  int bad = 0;

  md_ctrl dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_word_i(req_word_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_a_signed_o(mul_a_signed_o), .mul_b_signed_o(mul_b_signed_o),
    .mul_done_i(mul_done_i), .mul_prod_i(mul_prod_i),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_status_o(resp_status_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ext128(input logic [63:0] v, input logic s);
    return s ? {{64{v[63]}}, v} : {64'b0, v};
  endfunction

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] v, input logic s);
    return (s && v[63]) ? -v : v;
  endfunction

  // Reference: RISC-V M-extension results plus the controller's status reporting.
  function automatic void ref_model(input logic [3:0] op, input logic w, input logic [63:0] rs1,
                                    input logic [63:0] rs2, output logic [63:0] res, output logic [2:0] st);
    logic [3:0]   o;
    logic         sg;
    logic [63:0]  x, y, q, r;
    logic [127:0] p;
    o  = (op > 4'd7) ? 4'd0 : op;
    st = ST_NONE;
    if (o < 4'd4) begin
      if (w) o = 4'd0;
      p   = ext128(rs1, o == 4'd1 || o == 4'd2) * ext128(rs2, o == 4'd1);
      res = (o == 4'd0) ? p[63:0] : p[127:64];
    end else begin
      sg = (o == 4'd4) || (o == 4'd6);
      x  = w ? (sg ? sext32(rs1) : {32'b0, rs1[31:0]}) : rs1;
      y  = w ? (sg ? sext32(rs2) : {32'b0, rs2[31:0]}) : rs2;
      if (y == 64'd0) begin
        st = ST_ZERO_DIVISOR; q = '1; r = x;
      end else if (sg && x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000) && y == '1) begin
        st = ST_OVERFLOW; q = x; r = 64'd0;
      end else begin
        if (sg) begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
        end else begin
          q = x / y;
          r = x % y;
        end
`ifdef MD_DIV_FASTPATH_EN
        if (x == 64'd0) st = ST_ZERO_DIVIDEND;
        else if (mag(y, sg) > mag(x, sg)) st = ST_SHORT_DIV;
`endif
      end
      res = (o == 4'd6 || o == 4'd7) ? r : q;
    end
    if (w) res = sext32(res);
  endfunction

  // Behavioural multiplier / divider with configurable latency (0 = random 1..4 cycles).
  int lat_cfg = 0;
  int mul_cnt = 0, div_cnt = 0, mul_starts = 0, div_starts = 0, cyc = 0, done_cyc = 0;
  logic [63:0] cap_a = '0, cap_b = '0, cap_dvd = '0, cap_dvs = '0;
  logic        cap_as = 1'b0, cap_bs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    mul_done_i = 1'b0;
    div_done_i = 1'b0;
    if (reset) begin
      mul_cnt = 0;
      div_cnt = 0;
    end else begin
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin
          check("mul_hold_a", mul_a_o, cap_a);
          check("mul_hold_b", mul_b_o, cap_b);
          mul_prod_i = ext128(cap_a, cap_as) * ext128(cap_b, cap_bs);
          mul_done_i = 1'b1;
          done_cyc   = cyc;
        end
      end
      if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          check("div_hold_dvd", div_dividend_o, cap_dvd);
          check("div_hold_dvs", div_divisor_o, cap_dvs);
          div_quot_i = (cap_dvs == 64'd0) ? '1 : cap_dvd / cap_dvs;
          div_rem_i  = (cap_dvs == 64'd0) ? cap_dvd : cap_dvd % cap_dvs;
          div_done_i = 1'b1;
          done_cyc   = cyc;
        end
      end
      if (mul_start_o) begin
        mul_starts++;
        cap_a = mul_a_o; cap_b = mul_b_o; cap_as = mul_a_signed_o; cap_bs = mul_b_signed_o;
        mul_cnt = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      end
      if (div_start_o) begin
        div_starts++;
        cap_dvd = div_dividend_o; cap_dvs = div_divisor_o;
        div_cnt = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_d, input logic [2:0] exp_s, input int stall);
    int   n, ms0, ds0;
    logic is_mul, fast;
    is_mul = op[3] || !op[2];
    fast   = !is_mul && (exp_s != ST_NONE);
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = op; req_word_i = w; req_rs1_i = a; req_rs2_i = b;
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    check("req_ready", 64'(req_ready_o), 64'd1);
    ms0 = mul_starts;
    ds0 = div_starts;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (!resp_valid_o && n < 100) begin @(negedge clk); n++; end
    check("resp_valid", 64'(resp_valid_o), 64'd1);
    if (fast) check("fast_lat", 64'(n), 64'd0);
    else      check("unit_lat", 64'(cyc), 64'(done_cyc + 1));
    check("mul_starts", 64'(mul_starts - ms0), 64'(is_mul));
    check("div_starts", 64'(div_starts - ds0), 64'(!is_mul && !fast));
    check("data", resp_data_o, exp_d);
    check("status", 64'(resp_status_o), 64'(exp_s));
    $display("op=%0d w=%0d rs1=%h rs2=%h data=%h st=%0d", op, w, a, b, resp_data_o, resp_status_o);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid_o), 64'd1);
      check("hold_data", resp_data_o, exp_d);
      check("hold_status", 64'(resp_status_o), 64'(exp_s));
      check("ready_in_resp", 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    check("resp_drop", 64'(resp_valid_o), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [3:0]  op;
    logic        w;
    logic [63:0] a, b, ed;
    logic [2:0]  es;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_valid", 64'(resp_valid_o), 64'd0);
    check("rst_status", 64'(resp_status_o), 64'(ST_NONE));
    check("rst_data", resp_data_o, 64'd0);
    check("rst_starts", 64'({mul_start_o, div_start_o}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(req_ready_o), 64'd1);

    run_op(4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ST_NONE, 0);
    check("div_dividend", cap_dvd, 64'd7);
    check("div_divisor", cap_dvs, 64'd2);
    run_op(4'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ST_NONE, 0);
    run_op(4'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, ST_ZERO_DIVISOR, 0);
    run_op(4'd7, 1'b0, 64'd5, 64'd0, 64'd5, ST_ZERO_DIVISOR, 0);
    run_op(4'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, ST_OVERFLOW, 0);
    run_op(4'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, ST_OVERFLOW, 0);
    run_op(4'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ST_NONE, 0);
    check("mulhsu_a_signed", 64'(cap_as), 64'd1);
    check("mulhsu_b_signed", 64'(cap_bs), 64'd0);
    run_op(4'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ST_NONE, 1);
`ifdef MD_DIV_FASTPATH_EN
    run_op(4'd5, 1'b0, 64'd3, 64'd10, 64'd0, ST_SHORT_DIV, 3);
`else
    run_op(4'd5, 1'b0, 64'd3, 64'd10, 64'd0, ST_NONE, 3);
`endif

    // Flush in the second DIV_WAIT cycle; the late divider result must be swallowed.
    lat_cfg = 4;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 4'd4; req_word_i = 1'b0; req_rs1_i = 64'd100; req_rs2_i = 64'd7;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    req_valid_i = 1'b1; req_op_i = 4'd0; req_rs1_i = 64'd6; req_rs2_i = 64'd7;
    n = 0;
    while (!div_done_i && n < 20) begin
      check("flush_ready", 64'(req_ready_o), 64'd0);
      check("flush_valid", 64'(resp_valid_o), 64'd0);
      @(negedge clk);
      n++;
    end
    check("flush_done_seen", 64'(div_done_i), 64'd1);
    check("flush_ready_done", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("flush_reaccept", 64'(req_ready_o), 64'd1);
    check("flush_no_resp", 64'(resp_valid_o), 64'd0);
    req_valid_i = 1'b0;
    run_op(4'd0, 1'b0, 64'd6, 64'd7, 64'd42, ST_NONE, 0);

    // Reset in the middle of a divide returns straight to IDLE with no response.
    lat_cfg = 6;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 4'd4; req_rs1_i = 64'd100; req_rs2_i = 64'd7;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_mid_valid", 64'(resp_valid_o), 64'd0);
    end
    check("rst_mid_ready", 64'(req_ready_o), 64'd1);
    lat_cfg = 0;

    for (int t = 0; t < 150; t++) begin
      op = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      ref_model(op, w, a, b, ed, es);
      run_op(op, w, a, b, ed, es, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
